alu_share_arbiter: RTL and testbench

//   Shares one 32-bit alu instance between NUM_REQ requesters (e.g. execute stage, address-gen unit).

---
 rtl/alu_share_arbiter_pkg.sv | 20 ++
 rtl/alu_share_arbiter_alu.sv | 24 ++
 rtl/alu_share_arbiter_rr.sv | 33 +++
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU opcodes, arbiter FSM states, requester limit.
package alu_share_arbiter_pkg;

  localparam int ALU_ARB_MAX_REQ = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } alu_arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// 32-bit combinational ALU with zero flag; opcodes outside the defined set behave as ADD.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] res,
  output logic        zero_flag
);

  always_comb begin
    res = a + b;
    case (op)
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      default: res = a + b;
    endcase
    zero_flag = (res == 32'd0);
  end

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin pick: first asserted request strictly after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_vld
);

  int             cand;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant) + off) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!grant_vld && req[cand_idx]) begin
        grant_vld       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters, round-robin, one op in flight (grant T -> resp T+2).
// ALU_ARB_PERF_EN adds saturating per-requester grant and stall counters.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_left,
  input  logic [NUM_REQ*32-1:0] req_right,
  input  alu_op_t               req_op [NUM_REQ],
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_zero,
  output logic                  busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] perf_grants,
  output logic [NUM_REQ*32-1:0] perf_wait
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  alu_arb_state_t state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [31:0]    left_q, left_d, right_q, right_d;
  alu_op_t        op_q, op_d;
  logic [31:0]    resp_data_q, resp_data_d;
  logic           resp_zero_q, resp_zero_d;

  logic [NUM_REQ-1:0] grant, owner_oh;
  logic [IDW-1:0]     grant_idx;
  logic               grant_vld;
  logic [31:0]        alu_res;
  logic               alu_zero;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  alu u_alu (
    .a         (left_q),
    .b         (right_q),
    .op        (op_q),
    .res       (alu_res),
    .zero_flag (alu_zero)
  );

  // Handshake outputs are gated by rst so nothing is offered or accepted during reset.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    req_ready  = (!rst && state_q == S_IDLE) ? grant : '0;
    resp_valid = (!rst && state_q == S_RESP) ? owner_oh : '0;
    busy       = !rst && (state_q != S_IDLE);
    resp_data  = resp_data_q;
    resp_zero  = resp_zero_q;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    left_d       = left_q;
    right_d      = right_q;
    op_d         = op_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          left_d       = req_left[32*grant_idx +: 32];
          right_d      = req_right[32*grant_idx +: 32];
          op_d         = req_op[grant_idx];
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_data_d = alu_res;
        resp_zero_d = alu_zero;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      owner_q      <= '0;
      left_q       <= '0;
      right_q      <= '0;
      op_q         <= ALU_ADD;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      left_q       <= left_d;
      right_q      <= right_d;
      op_q         <= op_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grants_q [NUM_REQ];
  logic [31:0] grants_d [NUM_REQ];
  logic [31:0] wait_q   [NUM_REQ];
  logic [31:0] wait_d   [NUM_REQ];

  always_comb begin
    perf_grants = '0;
    perf_wait   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grants_d[i] = grants_q[i];
      wait_d[i]   = wait_q[i];
      if (req_valid[i] && req_ready[i] && grants_q[i] != 32'hFFFF_FFFF)
        grants_d[i] = grants_q[i] + 32'd1;
      if (req_valid[i] && !req_ready[i] && wait_q[i] != 32'hFFFF_FFFF)
        wait_d[i] = wait_q[i] + 32'd1;
      perf_grants[32*i +: 32] = grants_q[i];
      perf_wait[32*i +: 32]   = wait_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        grants_q[i] <= '0;
        wait_q[i]   <= '0;
      end else begin
        grants_q[i] <= grants_d[i];
        wait_q[i]   <= wait_d[i];
      end
    end
  end
`else
  // Counters are not built; the datapath above is identical either way.
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single ops plus hand-written multi-cycle sequences.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_left, req_right;
  alu_op_t       req_op [N];
  logic [31:0]   resp_data;
  logic          resp_zero, busy;
`ifdef ALU_ARB_PERF_EN
  logic [N*32-1:0] perf_grants, perf_wait;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_left   (req_left),
    .req_right  (req_right),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .busy       (busy)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grants(perf_grants),
    .perf_wait  (perf_wait)
`endif
  );

  typedef struct {
    int          id;
    alu_op_t     op;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp_d;
    logic        exp_z;
  } vec_t;

  vec_t vecs [8];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input alu_op_t op, input logic [31:0] l, input logic [31:0] r);
    req_left[32*id +: 32]  = l;
    req_right[32*id +: 32] = r;
    req_op[id]             = op;
  endtask

  // Single transaction from one requester, starting and ending at an idle negedge.
  task automatic run_vec(input int n, input vec_t v);
    logic [N-1:0] oh;
    oh       = '0;
    oh[v.id] = 1'b1;
    set_req(v.id, v.op, v.l, v.r);
    req_valid  = oh;
    resp_ready = '0;
    #1;
    chk($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'(oh));
    chk($sformatf("v%0d_busy_idle", n), 32'(busy), 32'd0);
    tick;
    req_valid = '0;
    #1;
    chk($sformatf("v%0d_busy_exec", n), 32'(busy), 32'd1);
    chk($sformatf("v%0d_no_resp_exec", n), 32'(resp_valid), 32'd0);
    tick;
    #1;
    chk($sformatf("v%0d_resp_valid", n), 32'(resp_valid), 32'(oh));
    chk($sformatf("v%0d_resp_data", n), resp_data, v.exp_d);
    chk($sformatf("v%0d_resp_zero", n), 32'(resp_zero), 32'(v.exp_z));
    resp_ready = oh;
    tick;
    resp_ready = '0;
    #1;
    chk($sformatf("v%0d_back_idle", n), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{0, ALU_SUB, 32'd9,          32'd9,          32'd0,          1'b1};
    vecs[2] = '{0, ALU_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
    vecs[3] = '{0, ALU_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
    vecs[4] = '{1, ALU_OR,  32'h1,          32'h2,          32'h3,          1'b0};
    vecs[5] = '{1, ALU_XOR, 32'hFFFF_FFFF,  32'h0000_FFFF,  32'hFFFF_0000,  1'b0};
    vecs[6] = '{1, ALU_ADD, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b1};
    vecs[7] = '{1, alu_op_t'(3'd7), 32'd2,  32'd3,          32'd5,          1'b0};

    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_left   = '0;
    req_right  = '0;
    req_op[0]  = ALU_ADD;
    req_op[1]  = ALU_ADD;
    tick;
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_zero", 32'(resp_zero), 32'd0);
    req_valid = '0;
    rst       = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Response held stable under backpressure; non-owner resp_ready and new requests ignored.
    do_reset;
    set_req(0, ALU_SUB, 32'd9, 32'd9);
    req_valid = 2'b01;
    #1 chk("hold_grant", 32'(req_ready), 32'b01);
    tick;
    req_valid = '0;
    tick;
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    req_valid  = 2'b10;
    resp_ready = 2'b10;
    for (int w = 0; w < 4; w++) begin
      #1;
      chk($sformatf("hold%0d_valid", w), 32'(resp_valid), 32'b01);
      chk($sformatf("hold%0d_data", w), resp_data, 32'd0);
      chk($sformatf("hold%0d_zero", w), 32'(resp_zero), 32'd1);
      chk($sformatf("hold%0d_busy", w), 32'(busy), 32'd1);
      chk($sformatf("hold%0d_no_grant", w), 32'(req_ready), 32'd0);
      tick;
    end
    req_valid  = '0;
    resp_ready = 2'b01;
    #1 chk("hold_last_valid", 32'(resp_valid), 32'b01);
    tick;
    resp_ready = '0;
    #1 chk("hold_released", 32'(busy), 32'd0);

    // Both requesters continuously valid: grants alternate starting with requester 0.
    do_reset;
    set_req(0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
    set_req(1, ALU_OR, 32'h1, 32'h2);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("rr%0d_grant", k), 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
      tick;
      tick;
      #1;
      chk($sformatf("rr%0d_resp_valid", k), 32'(resp_valid), (k % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("rr%0d_data", k), resp_data, (k % 2 == 0) ? 32'h0000_F000 : 32'h3);
      tick;
    end
    req_valid  = '0;
    resp_ready = '0;

    // Reset while executing: op dropped, priority returns to requester 0.
    do_reset;
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    set_req(1, ALU_XOR, 32'hFFFF_FFFF, 32'h0000_FFFF);
    req_valid = 2'b01;
    tick;
    req_valid = '0;
    rst       = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("postrst_data", resp_data, 32'd0);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    #1 chk("postrst_first_grant", 32'(req_ready), 32'b01);
    tick;
    tick;
    #1 chk("postrst_first_data", resp_data, 32'd12);
    tick;
    #1 chk("postrst_second_grant", 32'(req_ready), 32'b10);
    tick;
    tick;
    #1;
    chk("postrst_second_valid", 32'(resp_valid), 32'b10);
    chk("postrst_second_data", resp_data, 32'hFFFF_0000);
    req_valid = '0;
    tick;
    resp_ready = '0;

`ifdef ALU_ARB_PERF_EN
    // Four ops each; requester 0 granted on cycles 0,6,12,18 and requester 1 on 3,9,15,21.
    begin
      int expw0, expw1;
      logic [N-1:0] exp_rdy;
      expw0 = 0;
      expw1 = 0;
      do_reset;
      set_req(0, ALU_ADD, 32'd1, 32'd2);
      set_req(1, ALU_SUB, 32'd4, 32'd1);
      resp_ready = 2'b11;
      for (int cyc = 0; cyc < 24; cyc++) begin
        req_valid[0] = (cyc <= 18);
        req_valid[1] = (cyc <= 21);
        exp_rdy = (cyc % 6 == 0) ? 2'b01 : ((cyc % 6 == 3) ? 2'b10 : 2'b00);
        if (req_valid[0] && !exp_rdy[0]) expw0++;
        if (req_valid[1] && !exp_rdy[1]) expw1++;
        #1 chk($sformatf("perf_c%0d_ready", cyc), 32'(req_ready), 32'(exp_rdy));
        tick;
      end
      req_valid  = '0;
      resp_ready = '0;
      #1;
      chk("perf_grants0", perf_grants[31:0], 32'd4);
      chk("perf_grants1", perf_grants[63:32], 32'd4);
      chk("perf_wait0", perf_wait[31:0], 32'(expw0));
      chk("perf_wait1", perf_wait[63:32], 32'(expw1));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
